// File: rtl/salem_change_disp.sv
// salem_change_disp: pays out a two-digit BCD change amount one coin at a
// time through a request/acknowledge handshake with the coin hopper. Each
// coin is the largest denomination (20, 10, 5, 1) that fits the remainder
// and is still in stock. A per-denomination inventory is kept, and an
// unpaid remainder is reported when stock runs out.
module salem_change_disp #(
    parameter int INV_INIT = 8,
    parameter int LOW_TH   = 2
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       start,
    input  logic [7:0] amt_bcd,
    input  logic       refill,
    input  logic       coin_ack,
    output logic       coin_req,
    output logic [3:0] coin_sel,
    output logic       busy,
    output logic       done,
    output logic       short,
    output logic       bad,
    output logic [7:0] left_bcd,
    output logic [3:0] inv_low
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SELECT,
        REQ,
        DONE
    } state_t;

    localparam logic [7:0] INV_RELOAD = INV_INIT[7:0];

    state_t     state;
    logic [7:0] amt_q;
    logic [6:0] rem;
    logic [1:0] sel_idx;
    logic [7:0] inv [4];

    logic       pick_ok;
    logic [1:0] pick_idx;

    // Value in units of the coin at a given denomination index.
    function automatic logic [6:0] coin_val(input logic [1:0] idx);
        case (idx)
            2'd3:    return 7'd20;
            2'd2:    return 7'd10;
            2'd1:    return 7'd5;
            default: return 7'd1;
        endcase
    endfunction

    // Binary 0-99 back to two BCD digits by repeated subtraction of ten.
    function automatic logic [7:0] to_bcd(input logic [6:0] v);
        logic [3:0] t;
        logic [6:0] r;
        t = 4'd0;
        r = v;
        for (int i = 0; i < 9; i++) begin
            if (r >= 7'd10) begin
                r = r - 7'd10;
                t = t + 4'd1;
            end
        end
        return {t, r[3:0]};
    endfunction

    // Largest denomination that fits the remainder and is still in stock.
    always_comb begin
        pick_ok  = 1'b0;
        pick_idx = 2'd0;
        if (rem >= 7'd20 && inv[3] != 8'd0) begin
            pick_ok  = 1'b1;
            pick_idx = 2'd3;
        end else if (rem >= 7'd10 && inv[2] != 8'd0) begin
            pick_ok  = 1'b1;
            pick_idx = 2'd2;
        end else if (rem >= 7'd5 && inv[1] != 8'd0) begin
            pick_ok  = 1'b1;
            pick_idx = 2'd1;
        end else if (rem >= 7'd1 && inv[0] != 8'd0) begin
            pick_ok  = 1'b1;
            pick_idx = 2'd0;
        end
    end

    // Low-stock flags follow the inventory registers directly.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            inv_low[i] = (int'(inv[i]) < LOW_TH);
        end
    end

    // Moore control outputs decoded from the registered state.
    assign coin_req = (state == REQ);
    assign busy     = (state != IDLE);
    assign done     = (state == DONE);

    // Payout sequencer, inventory counters and sticky result registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= IDLE;
            amt_q    <= 8'h00;
            rem      <= 7'd0;
            sel_idx  <= 2'd0;
            coin_sel <= 4'b0000;
            short    <= 1'b0;
            bad      <= 1'b0;
            left_bcd <= 8'h00;
            for (int i = 0; i < 4; i++) begin
                inv[i] <= INV_RELOAD;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (refill) begin
                        for (int i = 0; i < 4; i++) begin
                            inv[i] <= INV_RELOAD;
                        end
                    end
                    if (start) begin
                        amt_q    <= amt_bcd;
                        short    <= 1'b0;
                        bad      <= 1'b0;
                        left_bcd <= 8'h00;
                        state    <= LOAD;
                    end
                end
                LOAD: begin
                    if (amt_q[7:4] > 4'd9 || amt_q[3:0] > 4'd9) begin
                        bad      <= 1'b1;
                        left_bcd <= 8'h00;
                        state    <= DONE;
                    end else begin
                        rem   <= 7'(amt_q[7:4]) * 7'd10 + 7'(amt_q[3:0]);
                        state <= SELECT;
                    end
                end
                SELECT: begin
                    if (rem == 7'd0) begin
                        left_bcd <= 8'h00;
                        state    <= DONE;
                    end else if (pick_ok) begin
                        sel_idx  <= pick_idx;
                        coin_sel <= 4'b0001 << pick_idx;
                        state    <= REQ;
                    end else begin
                        short    <= 1'b1;
                        left_bcd <= to_bcd(rem);
                        state    <= DONE;
                    end
                end
                REQ: begin
                    if (coin_ack) begin
                        rem          <= rem - coin_val(sel_idx);
                        inv[sel_idx] <= inv[sel_idx] - 8'd1;
                        coin_sel     <= 4'b0000;
                        state        <= SELECT;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_salem_change_disp.sv
// Testbench for salem_change_disp: directed payouts with hand-computed coin
// sequences and results pushed into a scoreboard, a hopper model that acks
// after a programmable wait, and a monitor that checks every coin request
// and every done pulse against the scoreboard.
module tb_salem_change_disp;

    logic       clk = 1'b0;
    logic       rstn;
    logic       start;
    logic [7:0] amt_bcd;
    logic       refill;
    logic       coin_ack;
    logic       coin_req;
    logic [3:0] coin_sel;
    logic       busy;
    logic       done;
    logic       short;
    logic       bad;
    logic [7:0] left_bcd;
    logic [3:0] inv_low;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int t_start = 0;

    bit hop_en   = 1'b1;
    int hop_wait = 0;

    typedef struct {
        bit         is_done;
        logic [3:0] sel;
        logic [7:0] left;
        logic       sh;
        logic       bd;
    } exp_t;

    exp_t sb[$];

    salem_change_disp #(.INV_INIT(8), .LOW_TH(2)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .start    (start),
        .amt_bcd  (amt_bcd),
        .refill   (refill),
        .coin_ack (coin_ack),
        .coin_req (coin_req),
        .coin_sel (coin_sel),
        .busy     (busy),
        .done     (done),
        .short    (short),
        .bad      (bad),
        .left_bcd (left_bcd),
        .inv_low  (inv_low)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Cycle counter used for latency measurements.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic pushCoin(input logic [3:0] s);
        exp_t e;
        e.is_done = 1'b0;
        e.sel     = s;
        e.left    = 8'h00;
        e.sh      = 1'b0;
        e.bd      = 1'b0;
        sb.push_back(e);
    endtask

    task automatic pushDone(input logic [7:0] l, input logic sh, input logic bd);
        exp_t e;
        e.is_done = 1'b1;
        e.sel     = 4'b0000;
        e.left    = l;
        e.sh      = sh;
        e.bd      = bd;
        sb.push_back(e);
    endtask

    // Issue a one-cycle start (optionally with refill) and return in cycle T+1.
    task automatic applyStimulus(input logic [7:0] a, input logic rf);
        @(negedge clk);
        start   = 1'b1;
        amt_bcd = a;
        refill  = rf;
        t_start = cyc;
        @(negedge clk);
        start  = 1'b0;
        refill = 1'b0;
    endtask

    // Wait, with a bound, for the done pulse and check its cycle offset from T.
    task automatic waitDone(input string name, input int exp_lat);
        int n;
        n = 0;
        while (!done && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!done) checkOutput({name, "_timeout"}, 32'd0, 32'd1);
        else       checkOutput({name, "_lat"}, 32'(cyc - t_start), 32'(exp_lat));
    endtask

    // Hopper model: acknowledges a request after hop_wait waiting cycles.
    initial begin
        int hop_cnt;
        hop_cnt  = 0;
        coin_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (coin_req && hop_en) begin
                coin_ack = (hop_cnt >= hop_wait);
                hop_cnt++;
            end else begin
                coin_ack = 1'b0;
                hop_cnt  = 0;
            end
        end
    end

    // Monitor: compares each new coin request and each done pulse to the scoreboard.
    initial begin
        logic       prev_req;
        logic [3:0] cur_sel;
        exp_t       e;
        prev_req = 1'b0;
        cur_sel  = 4'b0000;
        forever begin
            @(negedge clk);
            if (rstn) begin
                if (coin_req && !prev_req) begin
                    if (sb.size() == 0) begin
                        checkOutput("unexpected_coin", {28'd0, coin_sel}, 32'd0);
                    end else begin
                        e = sb.pop_front();
                        checkOutput("coin_kind", {31'd0, e.is_done}, 32'd0);
                        checkOutput("coin_sel", {28'd0, coin_sel}, {28'd0, e.sel});
                        cur_sel = e.sel;
                    end
                end else if (coin_req) begin
                    checkOutput("coin_sel_stable", {28'd0, coin_sel}, {28'd0, cur_sel});
                end
                if (done) begin
                    if (sb.size() == 0) begin
                        checkOutput("unexpected_done", 32'd1, 32'd0);
                    end else begin
                        e = sb.pop_front();
                        checkOutput("done_kind", {31'd0, e.is_done}, 32'd1);
                        checkOutput("left_bcd", {24'd0, left_bcd}, {24'd0, e.left});
                        checkOutput("short", {31'd0, short}, {31'd0, e.sh});
                        checkOutput("bad", {31'd0, bad}, {31'd0, e.bd});
                    end
                end
            end
            prev_req = coin_req;
        end
    end

    // Directed test sequence.
    initial begin
        int n;
        rstn    = 1'b0;
        start   = 1'b0;
        refill  = 1'b0;
        amt_bcd = 8'h00;
        #12;
        checkOutput("rst_coin_req", {31'd0, coin_req}, 32'd0);
        checkOutput("rst_coin_sel", {28'd0, coin_sel}, 32'd0);
        checkOutput("rst_busy", {31'd0, busy}, 32'd0);
        checkOutput("rst_done", {31'd0, done}, 32'd0);
        checkOutput("rst_short", {31'd0, short}, 32'd0);
        checkOutput("rst_bad", {31'd0, bad}, 32'd0);
        checkOutput("rst_left", {24'd0, left_bcd}, 32'd0);
        checkOutput("rst_inv_low", {28'd0, inv_low}, 32'd0);
        @(negedge clk);
        rstn = 1'b1;

        // 37 = 20 + 10 + 5 + 1 + 1; stock becomes 7,7,7,6.
        $display("[TB] payout 0x37");
        pushCoin(4'b1000); pushCoin(4'b0100); pushCoin(4'b0010);
        pushCoin(4'b0001); pushCoin(4'b0001);
        pushDone(8'h00, 1'b0, 1'b0);
        applyStimulus(8'h37, 1'b0);
        waitDone("p37", 13);
        checkOutput("p37_inv_low", {28'd0, inv_low}, 32'd0);

        // Illegal units digit: bad, done at T+2, no coins.
        $display("[TB] bad amount 0x3A");
        pushDone(8'h00, 1'b0, 1'b1);
        applyStimulus(8'h3A, 1'b0);
        waitDone("p3A", 2);
        @(negedge clk);
        checkOutput("bad_sticky", {31'd0, bad}, 32'd1);
        checkOutput("idle_busy", {31'd0, busy}, 32'd0);

        // One 5-coin with a slow hopper; a start while busy must be ignored.
        $display("[TB] payout 0x05 with slow ack");
        hop_wait = 10;
        pushCoin(4'b0010);
        pushDone(8'h00, 1'b0, 1'b0);
        applyStimulus(8'h05, 1'b0);
        repeat (3) @(negedge clk);
        checkOutput("busy_hold", {31'd0, busy}, 32'd1);
        start   = 1'b1;
        amt_bcd = 8'h99;
        @(negedge clk);
        start = 1'b0;
        waitDone("p05", 15);
        hop_wait = 0;

        // Reset while a 20 is requested: request drops at once, stock restored.
        $display("[TB] reset during request");
        hop_en = 1'b0;
        pushCoin(4'b1000);
        applyStimulus(8'h20, 1'b0);
        n = 0;
        while (!coin_req && n < 50) begin
            @(negedge clk);
            n++;
        end
        checkOutput("rst_req_seen", {31'd0, coin_req}, 32'd1);
        #2 rstn = 1'b0;
        #1;
        checkOutput("arst_coin_req", {31'd0, coin_req}, 32'd0);
        checkOutput("arst_coin_sel", {28'd0, coin_sel}, 32'd0);
        checkOutput("arst_busy", {31'd0, busy}, 32'd0);
        checkOutput("arst_inv_low", {28'd0, inv_low}, 32'd0);
        @(negedge clk);
        rstn   = 1'b1;
        hop_en = 1'b1;

        // Single 1-coin after reset; stock 8,8,8,7.
        $display("[TB] payout 0x01");
        pushCoin(4'b0001);
        pushDone(8'h00, 1'b0, 1'b0);
        applyStimulus(8'h01, 1'b0);
        waitDone("p01", 5);

        // 9 = 5 + 1*4; stock 8,8,7,3.
        $display("[TB] payout 0x09 twice");
        pushCoin(4'b0010);
        pushCoin(4'b0001); pushCoin(4'b0001); pushCoin(4'b0001); pushCoin(4'b0001);
        pushDone(8'h00, 1'b0, 1'b0);
        applyStimulus(8'h09, 1'b0);
        waitDone("p09a", 13);

        // Only three 1-coins left: 5 + 1*3, remainder 01 unpaid; stock 8,8,6,0.
        pushCoin(4'b0010);
        pushCoin(4'b0001); pushCoin(4'b0001); pushCoin(4'b0001);
        pushDone(8'h01, 1'b1, 1'b0);
        applyStimulus(8'h09, 1'b0);
        waitDone("p09b", 11);
        checkOutput("p09b_inv_low", {28'd0, inv_low}, 32'h1);

        // 99 = 20*4 + 10 + 5, 4 unpaid; stock 4,7,5,0.
        $display("[TB] payout 0x99 twice, refill while busy");
        pushCoin(4'b1000); pushCoin(4'b1000); pushCoin(4'b1000); pushCoin(4'b1000);
        pushCoin(4'b0100); pushCoin(4'b0010);
        pushDone(8'h04, 1'b1, 1'b0);
        applyStimulus(8'h99, 1'b0);
        waitDone("p99a", 15);

        // Same again draining the 20s; refill while busy must not help; stock 0,6,4,0.
        pushCoin(4'b1000); pushCoin(4'b1000); pushCoin(4'b1000); pushCoin(4'b1000);
        pushCoin(4'b0100); pushCoin(4'b0010);
        pushDone(8'h04, 1'b1, 1'b0);
        applyStimulus(8'h99, 1'b0);
        repeat (4) @(negedge clk);
        refill = 1'b1;
        @(negedge clk);
        refill = 1'b0;
        waitDone("p99b", 15);
        checkOutput("p99b_inv_low", {28'd0, inv_low}, 32'h9);

        // Refill together with start: refilled 20s pay one coin; stock 7,8,8,8.
        $display("[TB] refill with start 0x20");
        pushCoin(4'b1000);
        pushDone(8'h00, 1'b0, 1'b0);
        applyStimulus(8'h20, 1'b1);
        waitDone("p20", 5);
        checkOutput("p20_inv_low", {28'd0, inv_low}, 32'd0);

        repeat (3) @(negedge clk);
        checkOutput("sb_empty", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
